one_to_two_stream_demux: RTL and testbench



---
 rtl/one_to_two_stream_demux_pkg.sv | 22 ++
 rtl/one_to_two_stream_demux_if.sv | 38 +++
 rtl/one_to_two_stream_demux_stream_fifo.sv | 79 +++++++
 rtl/one_to_two_stream_demux.sv | 86 ++++++++
 tb/tb_one_to_two_stream_demux.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/one_to_two_stream_demux_pkg.sv
// Shared definitions for the one-to-two stream demux.
// Contents:
//   DATA_WIDTH   default payload width, shared with the MAC datapath
//   LANE0/LANE1  lane index constants
//   clog2()      ceiling log2, used to size FIFO pointers
package one_to_two_stream_demux_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/one_to_two_stream_demux_if.sv
// Handshake bundle between the operand source, the demux and the two MAC lanes.
// Signals:
//   in_data/in_sel/in_valid/in_ready       input stream (in_sel picks the lane)
//   out0_data/out0_valid/out0_ready        lane 0 stream
//   out1_data/out1_valid/out1_ready        lane 1 stream
// Modports:
//   master  environment side: drives the input stream, consumes both lanes
//   slave   demux side
interface one_to_two_stream_demux_if
  import one_to_two_stream_demux_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

endinterface

// File: rtl/one_to_two_stream_demux_stream_fifo.sv
// stream_fifo: WIDTH x DEPTH synchronous FIFO, one per demux lane.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   push, push_data      write request and payload (ignored while full)
//   full                 count == DEPTH
//   pop, pop_data        read request (ignored while empty), head entry
//   empty                count == 0
// Storage is cleared on reset so pop_data reads 0 while the FIFO is reset.
// DEPTH must be a power of two (pointers wrap by natural overflow).
module stream_fifo
  import one_to_two_stream_demux_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/one_to_two_stream_demux.sv
// one_to_two_stream_demux: steers a valid/ready operand stream into one of
// two per-lane FIFOs so a stalled MAC lane only blocks traffic addressed to it.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; discards all buffered data
//   bus    one_to_two_stream_demux_if.slave (input stream + two lane streams)
// Optional build macro DEMUX_RR_EN: in_sel is ignored and an internal
// round-robin bit alternates lanes on every accepted transfer; a full
// round-robin lane stalls the input rather than skipping to the other lane.
module one_to_two_stream_demux
  import one_to_two_stream_demux_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  one_to_two_stream_demux_if.slave  bus
);

  logic lane;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;
  logic full0, full1;
  logic empty0, empty1;

`ifdef DEMUX_RR_EN
  logic rr_q, rr_d;

  assign rr_d = rr_q ^ accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign lane = rr_q;
`else
  assign lane = bus.in_sel;
`endif

  // in_ready depends only on the selected lane's fill level, never on the
  // downstream ready, so a full lane refuses input even while it is popping.
  assign bus.in_ready = !reset && ((lane == LANE1) ? !full1 : !full0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push0        = accept && (lane == LANE0);
  assign push1        = accept && (lane == LANE1);

  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;
  assign pop0           = bus.out0_ready && !empty0;
  assign pop1           = bus.out1_ready && !empty1;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane0_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (bus.in_data),
    .full      (full0),
    .pop       (pop0),
    .pop_data  (bus.out0_data),
    .empty     (empty0)
  );

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane1_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (bus.in_data),
    .full      (full1),
    .pop       (pop1),
    .pop_data  (bus.out1_data),
    .empty     (empty1)
  );

endmodule

// File: tb/tb_one_to_two_stream_demux.sv
// Directed testbench for one_to_two_stream_demux with a per-lane scoreboard.
module tb_one_to_two_stream_demux;
  import one_to_two_stream_demux_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  one_to_two_stream_demux_if #(.WIDTH(WIDTH)) bus_if ();

  one_to_two_stream_demux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic rr_m = 1'b0;
  logic lane_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the task returns at the
  // following falling edge where outputs are stable for checking.
  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    bus_if.in_valid   = v;
    bus_if.in_sel     = s;
    bus_if.in_data    = d;
    bus_if.out0_ready = r0;
    bus_if.out1_ready = r1;
    @(negedge clk);
  endtask

  // Scoreboard: at each falling edge, compare each lane head against the
  // expected queue, retire it if the consumer is ready, and record the
  // transfer that the coming rising edge will accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.out0_valid) begin
        if (q0.size() == 0) begin
          check("out0_spurious_valid", 32'(bus_if.out0_valid), 32'd0);
        end else begin
          check("out0_data", 32'(bus_if.out0_data), 32'(q0[0]));
          if (bus_if.out0_ready) void'(q0.pop_front());
        end
      end
      if (bus_if.out1_valid) begin
        if (q1.size() == 0) begin
          check("out1_spurious_valid", 32'(bus_if.out1_valid), 32'd0);
        end else begin
          check("out1_data", 32'(bus_if.out1_data), 32'(q1[0]));
          if (bus_if.out1_ready) void'(q1.pop_front());
        end
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
`ifdef DEMUX_RR_EN
        lane_m = rr_m;
        rr_m   = ~rr_m;
`else
        lane_m = bus_if.in_sel;
`endif
        if (lane_m == LANE1) q1.push_back(bus_if.in_data);
        else                 q0.push_back(bus_if.in_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.in_valid   = 1'b0;
    bus_if.in_sel     = 1'b0;
    bus_if.in_data    = '0;
    bus_if.out0_ready = 1'b0;
    bus_if.out1_ready = 1'b0;
    #1;
    reset = 1'b1;

    @(negedge clk);
    check("rst_out0_valid", 32'(bus_if.out0_valid), 32'd0);
    check("rst_out1_valid", 32'(bus_if.out1_valid), 32'd0);
    check("rst_out0_data",  32'(bus_if.out0_data),  32'd0);
    check("rst_out1_data",  32'(bus_if.out1_data),  32'd0);
    check("rst_in_ready",   32'(bus_if.in_ready),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_out0_valid", 32'(bus_if.out0_valid), 32'd0);
    check("idle_out1_valid", 32'(bus_if.out1_valid), 32'd0);
    check("idle_out0_data",  32'(bus_if.out0_data),  32'd0);
    check("idle_out1_data",  32'(bus_if.out1_data),  32'd0);
    check("idle_in_ready",   32'(bus_if.in_ready),   32'd1);

`ifndef DEMUX_RR_EN
    // basic routing
    drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
    check("route_in_ready0", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    check("route_out0_valid", 32'(bus_if.out0_valid), 32'd1);
    check("route_out1_idle",  32'(bus_if.out1_valid), 32'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    check("route_out1_valid", 32'(bus_if.out1_valid), 32'd1);
    check("route_out0_done",  32'(bus_if.out0_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("route_out1_done",  32'(bus_if.out1_valid), 32'd0);

    // lane 0 backpressure, lane 1 unaffected
    drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
    check("bp_rdy_a1", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1);
    check("bp_rdy_a2", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b0, 8'hA3, 1'b0, 1'b1);
    check("bp_full_a3", 32'(bus_if.in_ready), 32'd0);
    drive(1'b1, 1'b0, 8'hA3, 1'b0, 1'b1);
    check("bp_full_hold", 32'(bus_if.in_ready), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'hB1, 1'b0, 1'b1);
    check("bp_lane1_rdy", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b0, 8'hA3, 1'b0, 1'b1);
    check("bp_lane1_valid", 32'(bus_if.out1_valid), 32'd1);
    check("bp_a3_refused",  32'(bus_if.in_ready),   32'd0);
    drive(1'b1, 1'b0, 8'hA3, 1'b1, 1'b1);
    check("bp_full_while_pop", 32'(bus_if.in_ready), 32'd0);
    drive(1'b1, 1'b0, 8'hA3, 1'b1, 1'b1);
    check("bp_a3_accepted", 32'(bus_if.in_ready), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("bp_a3_visible", 32'(bus_if.out0_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("bp_drained", 32'(bus_if.out0_valid), 32'd0);

    // lane 1 push+pop at count 1 with pointer wrap
    drive(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    check("pp_first_rdy", 32'(bus_if.in_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      check("pp_valid", 32'(bus_if.out1_valid), 32'd1);
      check("pp_rdy",   32'(bus_if.in_ready),   32'd1);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("pp_last_valid", 32'(bus_if.out1_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("pp_drained", 32'(bus_if.out1_valid), 32'd0);

    // asynchronous reset with lane 0 full
    drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("mrst_pre_valid", 32'(bus_if.out0_valid), 32'd1);
    check("mrst_pre_full",  32'(bus_if.in_ready),   32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("mrst_async_valid", 32'(bus_if.out0_valid), 32'd0);
    check("mrst_async_data",  32'(bus_if.out0_data),  32'd0);
    check("mrst_async_rdy",   32'(bus_if.in_ready),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.out0_ready = 1'b1;
    bus_if.out1_ready = 1'b1;
    @(negedge clk);
    check("mrst_post_valid", 32'(bus_if.out0_valid), 32'd0);
    check("mrst_post_rdy",   32'(bus_if.in_ready),   32'd1);
    drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("mrst_resume_valid", 32'(bus_if.out0_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`else
    // round-robin alternation with in_sel held at 1
    drive(1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
    check("rr_rdy_01", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'h02, 1'b1, 1'b1);
    check("rr_rdy_02",    32'(bus_if.in_ready),   32'd1);
    check("rr_01_lane0",  32'(bus_if.out0_valid), 32'd1);
    check("rr_01_lane1",  32'(bus_if.out1_valid), 32'd0);
    drive(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    check("rr_rdy_03",    32'(bus_if.in_ready),   32'd1);
    check("rr_02_lane1",  32'(bus_if.out1_valid), 32'd1);
    drive(1'b1, 1'b1, 8'h04, 1'b1, 1'b1);
    check("rr_rdy_04", 32'(bus_if.in_ready), 32'd1);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

    // full round-robin lane stalls even though the other lane has room
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
    check("rr_rdy_11", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'h12, 1'b0, 1'b1);
    check("rr_rdy_12", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'h13, 1'b0, 1'b1);
    check("rr_rdy_13", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'h14, 1'b0, 1'b1);
    check("rr_rdy_14", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'h15, 1'b0, 1'b1);
    check("rr_stall_no_skip", 32'(bus_if.in_ready), 32'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
`endif

    check("end_out0_idle", 32'(bus_if.out0_valid), 32'd0);
    check("end_out1_idle", 32'(bus_if.out1_valid), 32'd0);
    check("end_q0_empty",  32'(q0.size()), 32'd0);
    check("end_q1_empty",  32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
